// File: rtl/lcd_pkg.sv
// Shared types and timing constants for the 4-bit character-LCD writer.
// LCD_POWERON_INIT_EN adds the power-on states and the init nibble table.
package lcd_pkg;

  localparam int unsigned CNT_W = 20;

  localparam int unsigned DEF_SETUP_CYC      = 2;
  localparam int unsigned DEF_PULSE_CYC      = 12;
  localparam int unsigned DEF_HOLD_CYC       = 1;
  localparam int unsigned DEF_NIBBLE_GAP_CYC = 50;
  localparam int unsigned DEF_BYTE_GAP_CYC   = 2000;
  localparam int unsigned DEF_CLEAR_GAP_CYC  = 82000;

  localparam logic [7:0] OP_CLEAR     = 8'h01;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_HOME_ALT  = 8'h03;

  localparam int unsigned PWR_WAIT_CYC = 750000;
  localparam logic [1:0]  PWR_LAST_IDX = 2'd3;

  typedef enum logic [3:0] {
    IDLE, SETUP_H, PULSE_H, HOLD_H, GAP_N, SETUP_L, PULSE_L, HOLD_L, GAP_B
`ifdef LCD_POWERON_INIT_EN
    , PWR_WAIT, PWR_SETUP, PWR_PULSE, PWR_HOLD, PWR_GAP
`endif
  } state_e;

  // A zero-cycle delay is treated as one cycle.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == OP_CLEAR || d == OP_HOME || d == OP_HOME_ALT);
  endfunction

  function automatic logic [3:0] pwr_nibble(input logic [1:0] idx);
    return (idx == PWR_LAST_IDX) ? 4'h2 : 4'h3;
  endfunction

  function automatic int unsigned pwr_gap(input logic [1:0] idx);
    case (idx)
      2'd0:    return 205000;
      2'd1:    return 5000;
      default: return 2000;
    endcase
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable 20-bit down-counter that times every LCD delay; load wins over count.
// done is a flop decode (value == 0), so it is stable for the whole cycle.
module lcd_wait_timer
  import lcd_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign done  = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Byte-to-nibble LCD writer: one byte per handshake, busy 2*(S+P+H)+gapN+gapB cycles, in_ready only in IDLE.
// All LCD pins come from flops; LCD_POWERON_INIT_EN adds the 15 ms wait and 3/3/3/2 init nibbles.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC      = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC       = DEF_HOLD_CYC,
  parameter int unsigned NIBBLE_GAP_CYC = DEF_NIBBLE_GAP_CYC,
  parameter int unsigned BYTE_GAP_CYC   = DEF_BYTE_GAP_CYC,
  parameter int unsigned CLEAR_GAP_CYC  = DEF_CLEAR_GAP_CYC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] SF_D
);

`ifdef LCD_POWERON_INIT_EN
  localparam state_e RESET_STATE = PWR_WAIT;
`else
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e           state_q, state_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [3:0]       sf_d_q, sf_d_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] unused_tmr_value;
  logic             tmr_done;
`ifdef LCD_POWERON_INIT_EN
  logic [1:0]       pwr_idx_q, pwr_idx_d;
  logic             pwr_armed_q, pwr_armed_d;
`endif

  lcd_wait_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (unused_tmr_value),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    data_d       = data_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
`ifdef LCD_POWERON_INIT_EN
    pwr_idx_d    = pwr_idx_q;
    pwr_armed_d  = pwr_armed_q;
`endif
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d      = SETUP_H;
        rs_d         = in_rs;
        data_d       = in_data;
        tmr_load     = 1'b1;
        tmr_load_val = cyc_load(SETUP_CYC);
      end
      SETUP_H: if (tmr_done) begin
        state_d = PULSE_H; tmr_load = 1'b1; tmr_load_val = cyc_load(PULSE_CYC);
      end
      PULSE_H: if (tmr_done) begin
        state_d = HOLD_H; tmr_load = 1'b1; tmr_load_val = cyc_load(HOLD_CYC);
      end
      HOLD_H: if (tmr_done) begin
        state_d = GAP_N; tmr_load = 1'b1; tmr_load_val = cyc_load(NIBBLE_GAP_CYC);
      end
      GAP_N: if (tmr_done) begin
        state_d = SETUP_L; tmr_load = 1'b1; tmr_load_val = cyc_load(SETUP_CYC);
      end
      SETUP_L: if (tmr_done) begin
        state_d = PULSE_L; tmr_load = 1'b1; tmr_load_val = cyc_load(PULSE_CYC);
      end
      PULSE_L: if (tmr_done) begin
        state_d = HOLD_L; tmr_load = 1'b1; tmr_load_val = cyc_load(HOLD_CYC);
      end
      HOLD_L: if (tmr_done) begin
        state_d      = GAP_B;
        tmr_load     = 1'b1;
        tmr_load_val = is_slow_cmd(rs_q, data_q) ? cyc_load(CLEAR_GAP_CYC)
                                                 : cyc_load(BYTE_GAP_CYC);
      end
      GAP_B: if (tmr_done) state_d = IDLE;
`ifdef LCD_POWERON_INIT_EN
      // First cycle arms the wait; the arming cycle counts toward the 15 ms.
      PWR_WAIT: begin
        if (!pwr_armed_q) begin
          pwr_armed_d  = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = cyc_load(PWR_WAIT_CYC - 1);
        end else if (tmr_done) begin
          state_d = PWR_SETUP; tmr_load = 1'b1; tmr_load_val = cyc_load(SETUP_CYC);
        end
      end
      PWR_SETUP: if (tmr_done) begin
        state_d = PWR_PULSE; tmr_load = 1'b1; tmr_load_val = cyc_load(PULSE_CYC);
      end
      PWR_PULSE: if (tmr_done) begin
        state_d = PWR_HOLD; tmr_load = 1'b1; tmr_load_val = cyc_load(HOLD_CYC);
      end
      PWR_HOLD: if (tmr_done) begin
        state_d = PWR_GAP; tmr_load = 1'b1; tmr_load_val = cyc_load(pwr_gap(pwr_idx_q));
      end
      PWR_GAP: if (tmr_done) begin
        if (pwr_idx_q == PWR_LAST_IDX) begin
          state_d = IDLE;
        end else begin
          pwr_idx_d    = pwr_idx_q + 2'd1;
          state_d      = PWR_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = cyc_load(SETUP_CYC);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Pins are computed from the next state so they can be registered without lag.
  always_comb begin
    lcd_e_d  = 1'b0;
    lcd_rs_d = 1'b0;
    sf_d_d   = 4'h0;
    case (state_d)
      SETUP_H, HOLD_H, GAP_N: begin
        lcd_rs_d = rs_d; sf_d_d = data_d[7:4];
      end
      PULSE_H: begin
        lcd_e_d = 1'b1; lcd_rs_d = rs_d; sf_d_d = data_d[7:4];
      end
      SETUP_L, HOLD_L, GAP_B: begin
        lcd_rs_d = rs_d; sf_d_d = data_d[3:0];
      end
      PULSE_L: begin
        lcd_e_d = 1'b1; lcd_rs_d = rs_d; sf_d_d = data_d[3:0];
      end
`ifdef LCD_POWERON_INIT_EN
      PWR_SETUP, PWR_HOLD, PWR_GAP: sf_d_d = pwr_nibble(pwr_idx_d);
      PWR_PULSE: begin
        lcd_e_d = 1'b1; sf_d_d = pwr_nibble(pwr_idx_d);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      sf_d_q      <= 4'h0;
`ifdef LCD_POWERON_INIT_EN
      pwr_idx_q   <= 2'd0;
      pwr_armed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      sf_d_q      <= sf_d_d;
`ifdef LCD_POWERON_INIT_EN
      pwr_idx_q   <= pwr_idx_d;
      pwr_armed_q <= pwr_armed_d;
`endif
    end
  end

  assign in_ready = (state_q == IDLE);
  assign LCD_E    = lcd_e_q;
  assign LCD_RS   = lcd_rs_q;
  assign LCD_RW   = 1'b0;
  assign SF_D     = sf_d_q;

endmodule
